// File: rtl/dff_pkg.sv
// dff_pkg: shared width, data word type and reset constant for the dff_sync_rstn family
package dff_pkg;
  localparam int DFF_DEFAULT_WIDTH = 1;
  typedef logic [DFF_DEFAULT_WIDTH-1:0] dff_word_t;
  localparam dff_word_t DFF_DEFAULT_RESET = '0;
endpackage

// File: rtl/dff_sync_rstn_bit.sv
// dff_sync_rstn_bit: single-bit flop with synchronous active-low reset and complement output
module dff_sync_rstn_bit
  import dff_pkg::*;
#(
  parameter logic RESET_VALUE = DFF_DEFAULT_RESET[0]
) (
  input  logic clk,
  input  logic reset_n,
  input  logic d,
  output logic q,
  output logic q_not
);
  logic q_q, q_d;
  always_comb q_d = reset_n ? d : RESET_VALUE;
  always_ff @(posedge clk) q_q <= q_d;
  // q_not is derived from the same flop so it can never disagree with q
  assign q = q_q;
  assign q_not = ~q_q;
endmodule

// File: rtl/dff_sync_rstn.sv
// dff_sync_rstn: WIDTH-bit register with synchronous active-low reset and complementary outputs.
// Define DFF_SYNC_RSTN_ASSERT_EN to compile in simulation-only assertions and coverage.
module dff_sync_rstn
  import dff_pkg::*;
#(
  parameter int                 WIDTH       = DFF_DEFAULT_WIDTH,
  parameter logic [WIDTH-1:0]   RESET_VALUE = WIDTH'(DFF_DEFAULT_RESET)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] q_not
);
  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    dff_sync_rstn_bit #(.RESET_VALUE(RESET_VALUE[i])) u_bit (
      .clk    (clk),
      .reset_n(reset_n),
      .d      (d[i]),
      .q      (q[i]),
      .q_not  (q_not[i])
    );
  end
`ifdef DFF_SYNC_RSTN_ASSERT_EN
  // outputs are undefined until the first edge, so history-based checks wait for it
  logic valid_q;
  always_ff @(posedge clk) valid_q <= 1'b1;
  always_ff @(posedge clk)
    if (valid_q) a_not_imm: assert (q_not == ~q) else $error("q_not %h is not ~q %h", q_not, q);
  a_not: assert property (@(posedge clk) valid_q |-> q_not == ~q)
    else $error("q_not does not complement q");
  a_rst: assert property (@(posedge clk) valid_q && !reset_n |=> q == RESET_VALUE)
    else $error("q not reset value after reset");
  a_load: assert property (@(posedge clk) valid_q && reset_n |=> q == $past(d))
    else $error("q does not match loaded d");
  c_rst: cover property (@(posedge clk) valid_q && !reset_n);
  c_rel: cover property (@(posedge clk) valid_q && !reset_n ##1 reset_n);
  c_ones: cover property (@(posedge clk) reset_n && d == {WIDTH{1'b1}});
  c_zeros: cover property (@(posedge clk) reset_n && d == '0);
`endif
endmodule

// File: tb/tb_dff_sync_rstn.sv
// tb_dff_sync_rstn: randomized directed bench for 1-bit default and 8-bit A5-reset registers
module tb_dff_sync_rstn;
  logic clk = 1'b0;
  logic reset_n;
  logic d1;
  logic [7:0] d8;
  logic q1, qn1;
  logic [7:0] q8, qn8;
  int vectors = 0;
  int miscompares = 0;
  logic p1;
  logic [7:0] p8;
  always #10 clk = ~clk;
  dff_sync_rstn u_w1 (.clk(clk), .reset_n(reset_n), .d(d1), .q(q1), .q_not(qn1));
  dff_sync_rstn #(.WIDTH(8), .RESET_VALUE(8'hA5)) u_w8 (
    .clk(clk), .reset_n(reset_n), .d(d8), .q(q8), .q_not(qn8)
  );
  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask
  task automatic chk_all(input string tag);
    chk({tag, " q1"}, {7'd0, q1}, {7'd0, p1});
    chk({tag, " qn1"}, {7'd0, qn1}, {7'd0, ~p1});
    chk({tag, " q8"}, q8, p8);
    chk({tag, " qn8"}, qn8, ~p8);
  endtask
  // entered 1 unit after an edge; noise on d (and on reset_n when staying out of reset)
  // between edges must not matter, only the values settled before the next edge
  task automatic cyc(input logic [7:0] dv8, input logic dv1, input logic rn);
    #1;
    reset_n = rn ? 1'($urandom_range(0, 1)) : 1'b0;
    d8 = 8'($urandom);
    d1 = 1'($urandom);
    #4;
    d8 = 8'($urandom);
    d1 = ~d1;
    if (rn) reset_n = 1'b1;
    #4;
    if (rn) reset_n = 1'($urandom_range(0, 1));
    #2;
    d8 = dv8;
    d1 = dv1;
    reset_n = rn;
    #6;
    chk_all("hold");
    @(posedge clk);
    #1;
    p1 = rn ? dv1 : 1'b0;
    p8 = rn ? dv8 : 8'hA5;
    chk_all("edge");
  endtask
  initial begin
    reset_n = 1'b0;
    d1 = 1'b1;
    d8 = 8'hFF;
    @(posedge clk);
    #1;
    p1 = 1'b0;
    p8 = 8'hA5;
    chk_all("first_reset");
    for (int i = 0; i < 5; i++) cyc(8'($urandom), 1'($urandom), 1'b0);
    cyc(8'h3C, 1'b1, 1'b1);
    for (int i = 0; i < 10; i++) cyc(8'($urandom), 1'($urandom), 1'b1);
    cyc(8'hFF, 1'b1, 1'b1);
    cyc(8'hFF, 1'b1, 1'b0);
    cyc(8'hFF, 1'b1, 1'b1);
    cyc(8'hFF, 1'b1, 1'b1);
    cyc(8'h00, 1'b0, 1'b1);
    cyc(8'hFF, 1'b1, 1'b1);
    for (int i = 0; i < 20; i++) cyc(8'($urandom), 1'($urandom), 1'($urandom_range(0, 3) != 0));
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
